alu_md: RTL and testbench
=========================

# alu_md

Parametrised execute-stage ALU with an attached iterative multiply/divide unit and HI/LO registers. Combinational ops keep the existing 4-bit ALUControlE encoding and complete in the same cycle. mult/multu/div/divu run sequentially for WIDTH cycles, and BusyE stalls the pipeline meanwhile. Sits in the EX stage; ALUOutE feeds the EX/MEM register.

## Interface
- WIDTH, 32, datapath width; even, ≥ 8. SH = $clog2(WIDTH).
- clk  in  1  clock, all state on rising edge
- reset  in  1  synchronous, active-high
- SrcAE  in  WIDTH  operand A / dividend / multiplicand
- SrcBE  in  WIDTH  operand B / divisor / multiplier
- ALUControlE  in  4  combinational op select
- MDControlE  in  3  000 none, 001 mult, 010 multu, 011 div, 100 divu, 101 mthi, 110 mtlo, 111 none
- StartE  in  1  request strobe for MDControlE op
- ALUOutE  out  WIDTH  combinational result
- ZeroE  out  1  ALUOutE == 0
- HiE, LoE  out  WIDTH  architectural HI/LO registers
- BusyE  out  1  mul/div in progress

## Operation
- ALUControlE: 0000 and, 0001 sllv (A << B[SH-1:0]), 0010 or, 0011 srav (signed A >>> B[SH-1:0]), 0100 add, 0101 srlv, 0110 xor, 0111 mfhi (HiE), 1000 sltu, 1001 mflo (LoE), 1010 nor, 1100 sub, 1101 lui (B << WIDTH/2), 1110 slt (signed). 1011, 1111: result 0. Add/sub wrap modulo 2^WIDTH.
- FSM states: IDLE, MUL, DIV.
- Accept: StartE=1, state IDLE, MDControlE ∈ {001..110}. StartE with MDControlE ∈ {000,111}, or while not IDLE, is ignored (no state change).
- mthi/mtlo: HI/LO ← SrcAE at accept edge; FSM stays IDLE, BusyE stays 0.
- mult/multu: latch |A|,|B| (signed) or A,B (unsigned) and the result sign; shift-add 1 bit/cycle into a 2·WIDTH accumulator. On the final step {HI,LO} ← product, two's-complement negated if signs differ.
- div/divu: restoring division on magnitudes, 1 quotient bit/cycle. On the final step LO ← quotient, negated if operand signs differ; HI ← remainder, sign of dividend.
- Divide by zero (B=0): runs the full WIDTH cycles; result LO = all ones, HI = dividend (unmodified SrcAE as latched).
- div MIN / −1: LO = MIN, HI = 0 (natural magnitude-path result).
- Operands are latched at accept; SrcAE/SrcBE may change during BusyE.
- mfhi/mflo during BusyE return the old HI/LO. The hazard unit stalls on BusyE.

## Timing
- Reset: state IDLE, HiE=LoE=0, BusyE=0, internal counter/accumulators 0. ALUOutE/ZeroE are purely combinational from the inputs and HI/LO.
- Reset asserted mid-operation aborts it. Next cycle: IDLE, BusyE=0, HI=LO=0.
- ALUOutE/ZeroE: 0-cycle latency, same cycle as inputs.
- mul/div accepted at edge k: BusyE=1 in cycles k+1 … k+WIDTH (exactly WIDTH cycles).
- HI/LO are written at the edge ending cycle k+WIDTH. New values and BusyE=0 are visible in cycle k+WIDTH+1.
- A new accept is possible at the edge ending cycle k+WIDTH+1 (the first IDLE cycle). Back-to-back issue interval is WIDTH+1 cycles.
- mthi/mtlo accepted at edge k: new HI/LO visible in cycle k+1.
- BusyE is registered (driven from state), not combinational from StartE.

## Test plan
- Combinational sweep (WIDTH=32): srav 0x80000000 by 4 → 0xF8000000; sllv by B=0x21 → shift by 1; lui 0x1234 → 0x12340000; slt −1,1 → 1; sltu −1,1 → 0; code 1011 → 0, ZeroE=1.
- mult −3 × 7: BusyE high exactly 32 cycles → HI=0xFFFFFFFF, LO=0xFFFFFFEB; multu 0xFFFFFFFF × 2 → HI=1, LO=0xFFFFFFFE.
- divu 100/7 → LO=14, HI=2; div −7/2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF; div 0x80000000/−1 → LO=0x80000000, HI=0.
- div 5/0 → LO=0xFFFFFFFF, HI=5. Operands changed mid-op do not affect the result.
- StartE with mult during BusyE is ignored: HI/LO reflect only the first op and BusyE drops after 32 cycles. mthi 0xA5 then mflo/mfhi on ALUOutE the next cycle → 0xA5 on mfhi.
- Reset at cycle 10 of a div → next cycle BusyE=0, HI=LO=0. A new divu accepted immediately completes correctly.
- Repeat a random mul/div regression against a reference model at WIDTH=8 and WIDTH=16.

Source files
------------

// File: rtl/alu_md.sv
// alu_md: execute-stage ALU with an iterative multiply/divide unit and HI/LO registers
module alu_md #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] SrcAE,
  input  logic [WIDTH-1:0] SrcBE,
  input  logic [3:0]       ALUControlE,
  input  logic [2:0]       MDControlE,
  input  logic             StartE,
  output logic [WIDTH-1:0] ALUOutE,
  output logic             ZeroE,
  output logic [WIDTH-1:0] HiE,
  output logic [WIDTH-1:0] LoE,
  output logic             BusyE
);
  localparam int SH = $clog2(WIDTH);
  typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;
  state_t state_q, state_d;
  logic [SH-1:0] cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, hi_q, hi_d, lo_q, lo_d;
  logic neg_q, neg_d, sa_q, sa_d;
  logic is_signed, is_mul, is_div, accept, last;
  logic [SH-1:0] shamt;
  logic [WIDTH-1:0] a_mag, b_mag, quo, rem;
  logic [WIDTH:0] mul_sum, rem_sh, rem_sub;
  logic [2*WIDTH-1:0] mul_nxt, div_nxt, prod;

  always_comb begin
    shamt = SrcBE[SH-1:0];
    case (ALUControlE)
      4'b0000: ALUOutE = SrcAE & SrcBE;
      4'b0001: ALUOutE = SrcAE << shamt;
      4'b0010: ALUOutE = SrcAE | SrcBE;
      4'b0011: ALUOutE = $signed(SrcAE) >>> shamt;
      4'b0100: ALUOutE = SrcAE + SrcBE;
      4'b0101: ALUOutE = SrcAE >> shamt;
      4'b0110: ALUOutE = SrcAE ^ SrcBE;
      4'b0111: ALUOutE = hi_q;
      4'b1000: ALUOutE = WIDTH'(SrcAE < SrcBE);
      4'b1001: ALUOutE = lo_q;
      4'b1010: ALUOutE = ~(SrcAE | SrcBE);
      4'b1100: ALUOutE = SrcAE - SrcBE;
      4'b1101: ALUOutE = SrcBE << (WIDTH / 2);
      4'b1110: ALUOutE = WIDTH'($signed(SrcAE) < $signed(SrcBE));
      default: ALUOutE = '0;
    endcase
    ZeroE = ALUOutE == '0;
    HiE = hi_q;
    LoE = lo_q;
    BusyE = state_q != IDLE;
  end

  // one shift-add (mul) or restore-subtract (div) step per busy cycle
  always_comb begin
    is_signed = MDControlE == 3'b001 || MDControlE == 3'b011;
    is_mul = MDControlE == 3'b001 || MDControlE == 3'b010;
    is_div = MDControlE == 3'b011 || MDControlE == 3'b100;
    accept = StartE && state_q == IDLE && MDControlE != 3'b000 && MDControlE != 3'b111;
    a_mag = is_signed && SrcAE[WIDTH-1] ? -SrcAE : SrcAE;
    b_mag = is_signed && SrcBE[WIDTH-1] ? -SrcBE : SrcBE;
    last = cnt_q == SH'(WIDTH - 1);
    mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, b_q} : '0);
    mul_nxt = {mul_sum, acc_q[WIDTH-1:1]};
    prod = neg_q ? -mul_nxt : mul_nxt;
    rem_sh = acc_q[2*WIDTH-1:WIDTH-1];
    rem_sub = rem_sh - {1'b0, b_q};
    div_nxt = rem_sub[WIDTH] ? {rem_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0}
                             : {rem_sub[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
    quo = div_nxt[WIDTH-1:0];
    rem = div_nxt[2*WIDTH-1:WIDTH];
    state_d = state_q;
    cnt_d = state_q == IDLE ? '0 : cnt_q + 1'b1;
    acc_d = acc_q;
    a_d = a_q;
    b_d = b_q;
    neg_d = neg_q;
    sa_d = sa_q;
    hi_d = hi_q;
    lo_d = lo_q;
    if (accept) begin
      state_d = is_mul ? MUL : is_div ? DIV : IDLE;
      b_d = is_mul ? a_mag : b_mag;
      acc_d = {{WIDTH{1'b0}}, is_mul ? b_mag : a_mag};
      a_d = SrcAE;
      neg_d = is_signed && (SrcAE[WIDTH-1] ^ SrcBE[WIDTH-1]);
      sa_d = is_signed && SrcAE[WIDTH-1];
      hi_d = MDControlE == 3'b101 ? SrcAE : hi_q;
      lo_d = MDControlE == 3'b110 ? SrcAE : lo_q;
    end else if (state_q == MUL) begin
      acc_d = mul_nxt;
      if (last) begin
        state_d = IDLE;
        {hi_d, lo_d} = prod;
      end
    end else if (state_q == DIV) begin
      acc_d = div_nxt;
      if (last) begin
        state_d = IDLE;
        hi_d = b_q == '0 ? a_q : sa_q ? -rem : rem;
        lo_d = b_q == '0 ? '1 : neg_q ? -quo : quo;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q <= '0;
      acc_q <= '0;
      a_q <= '0;
      b_q <= '0;
      neg_q <= 1'b0;
      sa_q <= 1'b0;
      hi_q <= '0;
      lo_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      acc_q <= acc_d;
      a_q <= a_d;
      b_q <= b_d;
      neg_q <= neg_d;
      sa_q <= sa_d;
      hi_q <= hi_d;
      lo_q <= lo_d;
    end
  end
endmodule

// File: tb/tb_alu_md.sv
// tb_alu_md: directed and random checks of alu_md at WIDTH 32, 8 and 16
module tb_alu_md;
  logic clk = 1'b0;
  logic reset;
  logic [31:0] a, b;
  logic [3:0] alu_ctl;
  logic [2:0] md;
  logic [2:0] start;
  logic [31:0] out32, hi32, lo32;
  logic [7:0] out8, hi8, lo8;
  logic [15:0] out16, hi16, lo16;
  logic z32, z8, z16, busy32, busy8, busy16;
  logic [31:0] out_s, hi_s, lo_s;
  logic busy_s;
  int sel;
  int checks = 0;
  int errors = 0;
  logic [31:0] prev_hi [int];
  typedef struct {string tag; logic [31:0] hi; logic [31:0] lo;} exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  alu_md #(.WIDTH(32)) u32 (.clk(clk), .reset(reset), .SrcAE(a), .SrcBE(b), .ALUControlE(alu_ctl),
    .MDControlE(md), .StartE(start[0]), .ALUOutE(out32), .ZeroE(z32), .HiE(hi32), .LoE(lo32), .BusyE(busy32));
  alu_md #(.WIDTH(8)) u8 (.clk(clk), .reset(reset), .SrcAE(a[7:0]), .SrcBE(b[7:0]), .ALUControlE(alu_ctl),
    .MDControlE(md), .StartE(start[1]), .ALUOutE(out8), .ZeroE(z8), .HiE(hi8), .LoE(lo8), .BusyE(busy8));
  alu_md #(.WIDTH(16)) u16 (.clk(clk), .reset(reset), .SrcAE(a[15:0]), .SrcBE(b[15:0]), .ALUControlE(alu_ctl),
    .MDControlE(md), .StartE(start[2]), .ALUOutE(out16), .ZeroE(z16), .HiE(hi16), .LoE(lo16), .BusyE(busy16));

  always_comb begin
    out_s = sel == 8 ? {24'd0, out8} : sel == 16 ? {16'd0, out16} : out32;
    hi_s = sel == 8 ? {24'd0, hi8} : sel == 16 ? {16'd0, hi16} : hi32;
    lo_s = sel == 8 ? {24'd0, lo8} : sel == 16 ? {16'd0, lo16} : lo32;
    busy_s = sel == 8 ? busy8 : sel == 16 ? busy16 : busy32;
  end

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] model(int w, logic [2:0] op, logic [31:0] x, logic [31:0] y);
    logic [63:0] mask, ux, uy, up, hi, lo;
    longint sx, sy, sp;
    mask = (64'd1 << w) - 64'd1;
    ux = {32'd0, x} & mask;
    uy = {32'd0, y} & mask;
    sx = longint'(ux ^ (64'd1 << (w - 1))) - longint'(64'd1 << (w - 1));
    sy = longint'(uy ^ (64'd1 << (w - 1))) - longint'(64'd1 << (w - 1));
    hi = '0;
    lo = '0;
    if (op == 3'b001) begin
      sp = sx * sy;
      hi = 64'(sp >>> w) & mask;
      lo = 64'(sp) & mask;
    end else if (op == 3'b010) begin
      up = ux * uy;
      hi = (up >> w) & mask;
      lo = up & mask;
    end else if (uy == 0) begin
      hi = ux;
      lo = mask;
    end else if (op == 3'b011) begin
      lo = 64'(sx / sy) & mask;
      hi = 64'(sx % sy) & mask;
    end else begin
      lo = ux / uy;
      hi = ux % uy;
    end
    return {hi[31:0], lo[31:0]};
  endfunction

  // poke >= 0 issues an extra mult that many cycles into the op; it must be ignored
  task automatic run_md(string tag, int w, logic [2:0] op, logic [31:0] x, logic [31:0] y,
                        logic [31:0] ehi, logic [31:0] elo, int poke);
    int n;
    exp_t e;
    sel = w;
    alu_ctl = 4'b0111;
    a = x;
    b = y;
    md = op;
    start = w == 8 ? 3'b010 : w == 16 ? 3'b100 : 3'b001;
    sb.push_back('{tag, ehi, elo});
    @(negedge clk);
    start = '0;
    md = '0;
    n = 0;
    while (busy_s && n < 100) begin
      if (n == 1) chk({tag, "_old_hi"}, out_s, prev_hi[w]);
      a = $urandom;
      b = $urandom;
      if (n == poke) begin
        md = 3'b001;
        start = w == 8 ? 3'b010 : w == 16 ? 3'b100 : 3'b001;
      end else begin
        md = '0;
        start = '0;
      end
      @(negedge clk);
      n++;
    end
    start = '0;
    md = '0;
    chk({tag, "_busy_cycles"}, 32'(n), 32'(w));
    e = sb.pop_front();
    chk({e.tag, "_hi"}, hi_s, e.hi);
    chk({e.tag, "_lo"}, lo_s, e.lo);
    prev_hi[w] = e.hi;
  endtask

  logic [3:0] c_ctl [12] = '{4'b0011, 4'b0001, 4'b1101, 4'b1110, 4'b1000, 4'b1011,
                             4'b0100, 4'b1100, 4'b0000, 4'b1010, 4'b0101, 4'b0110};
  logic [31:0] c_a [12] = '{32'h80000000, 32'h1, 32'h0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h12345678,
                            32'hFFFFFFFF, 32'h0, 32'hF0F0F0F0, 32'hF0F0F0F0, 32'h80000000, 32'hFF00FF00};
  logic [31:0] c_b [12] = '{32'h4, 32'h21, 32'h1234, 32'h1, 32'h1, 32'h9ABCDEF0,
                            32'h1, 32'h1, 32'h0FF00FF0, 32'h0F00000F, 32'h24, 32'h0FF00FF0};
  logic [31:0] c_e [12] = '{32'hF8000000, 32'h2, 32'h12340000, 32'h1, 32'h0, 32'h0,
                            32'h0, 32'hFFFFFFFF, 32'h00F000F0, 32'h000F0F00, 32'h08000000, 32'hF0F0F0F0};

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] r;
    logic [31:0] x, y;
    logic [2:0] op;
    prev_hi[32] = '0;
    prev_hi[8] = '0;
    prev_hi[16] = '0;
    sel = 32;
    reset = 1'b1;
    a = '0;
    b = '0;
    alu_ctl = '0;
    md = '0;
    start = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rst_hi", hi32, 32'h0);
    chk("rst_lo", lo32, 32'h0);
    chk("rst_busy", {31'd0, busy32}, 32'h0);
    chk("rst_busy8_16", {30'd0, busy8, busy16}, 32'h0);
    chk("rst_zero8_16", {30'd0, z8, z16}, 32'h3);
    for (int i = 0; i < 12; i++) begin
      alu_ctl = c_ctl[i];
      a = c_a[i];
      b = c_b[i];
      #1;
      chk($sformatf("alu_%b", c_ctl[i]), out32, c_e[i]);
      chk($sformatf("zero_%b", c_ctl[i]), {31'd0, z32}, {31'd0, c_e[i] == 32'd0});
    end
    @(negedge clk);
    run_md("mult_neg", 32, 3'b001, 32'hFFFFFFFD, 32'd7, 32'hFFFFFFFF, 32'hFFFFFFEB, -1);
    run_md("multu_max", 32, 3'b010, 32'hFFFFFFFF, 32'd2, 32'h1, 32'hFFFFFFFE, -1);
    run_md("divu_100_7", 32, 3'b100, 32'd100, 32'd7, 32'd2, 32'd14, -1);
    run_md("div_m7_2", 32, 3'b011, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, -1);
    run_md("div_min_m1", 32, 3'b011, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000, -1);
    run_md("div_by_zero", 32, 3'b011, 32'd5, 32'd0, 32'd5, 32'hFFFFFFFF, -1);
    run_md("mult_poke", 32, 3'b001, 32'd3, 32'd5, 32'd0, 32'd15, 4);
    chk("poke_idle", {31'd0, busy32}, 32'h0);
    md = 3'b101;
    a = 32'hA5;
    start = 3'b001;
    @(negedge clk);
    start = '0;
    md = '0;
    alu_ctl = 4'b0111;
    #1;
    chk("mthi_mfhi", out32, 32'hA5);
    chk("mthi_busy", {31'd0, busy32}, 32'h0);
    alu_ctl = 4'b1001;
    #1;
    chk("mthi_mflo", out32, 32'd15);
    md = 3'b110;
    a = 32'h5A;
    start = 3'b001;
    @(negedge clk);
    start = '0;
    md = '0;
    #1;
    chk("mtlo_mflo", out32, 32'h5A);
    md = 3'b111;
    start = 3'b001;
    @(negedge clk);
    start = '0;
    md = '0;
    chk("md111_ignored", {31'd0, busy32}, 32'h0);
    md = 3'b011;
    a = 32'd100;
    b = 32'd3;
    start = 3'b001;
    @(negedge clk);
    start = '0;
    md = '0;
    repeat (9) @(negedge clk);
    chk("abort_busy_before", {31'd0, busy32}, 32'h1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    alu_ctl = 4'b0111;
    #1;
    chk("abort_busy", {31'd0, busy32}, 32'h0);
    chk("abort_hi", hi32, 32'h0);
    chk("abort_lo", lo32, 32'h0);
    chk("abort_zero", {31'd0, z32}, 32'h1);
    prev_hi[32] = '0;
    prev_hi[8] = '0;
    prev_hi[16] = '0;
    run_md("divu_after_abort", 32, 3'b100, 32'd1000, 32'd33, 32'd10, 32'd30, -1);
    for (int i = 0; i < 24; i++) begin
      op = 3'(1 + i % 4);
      x = $urandom;
      y = i % 5 == 0 ? 32'd0 : i % 7 == 0 ? 32'hFFFFFFFF : $urandom;
      r = model(8, op, x, y);
      run_md($sformatf("rnd8_%0d_op%0d", i, op), 8, op, x, y, r[63:32], r[31:0], -1);
      r = model(16, op, x, y);
      run_md($sformatf("rnd16_%0d_op%0d", i, op), 16, op, x, y, r[63:32], r[31:0], -1);
    end
    r = model(8, 3'b011, 32'h80, 32'hFF);
    run_md("div8_min_m1", 8, 3'b011, 32'h80, 32'hFF, r[63:32], r[31:0], -1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
